idex_stage: RTL and testbench

- ID/EX pipeline register for the 5-stage MIPS pipeline. Captures the decoded instruction from ID.
- Sole source of the IDEX_src1/src2/dest fields and EX control consumed by the forwarding unit and the EX datapath.
- Integrates load-use hazard detection: inserts a one-cycle bubble and freezes PC and IF/ID.
- Applies WB-to-ID register bypass, honours branch flush and downstream hold, and counts stall cycles.

---
 rtl/pipeline_pkg.sv | 37 +++
 rtl/idex_stage_if.sv | 43 ++++
 rtl/idex_stage_hazard_detect.sv | 50 +++++
 rtl/idex_stage.sv | 85 ++++++++
 tb/tb_idex_stage.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: widths, EX control bundle and the ID/EX register image.
package pipeline_pkg;
   localparam int DATA_W  = 32;
   localparam int REG_W   = 5;
   localparam int ALUOP_W = 4;

   typedef struct packed {
      logic               reg_write;
      logic               mem_read;
      logic               mem_write;
      logic               mem_to_reg;
      logic               alu_src;
      logic [ALUOP_W-1:0] alu_op;
   } ex_ctrl_t;

   localparam ex_ctrl_t BUBBLE_CTRL = '0;

   typedef struct packed {
      logic              valid;
      ex_ctrl_t          ctrl;
      logic [REG_W-1:0]  src1;
      logic [REG_W-1:0]  src2;
      logic [REG_W-1:0]  dest;
      logic [DATA_W-1:0] rdata1;
      logic [DATA_W-1:0] rdata2;
      logic [DATA_W-1:0] imm;
   } idex_t;

   // Register $0 is hardwired, so a WB write to it must never be forwarded.
   function automatic logic [DATA_W-1:0] wb_bypass(input logic              wb_we,
                                                   input logic [REG_W-1:0]  wb_dest,
                                                   input logic [DATA_W-1:0] wb_data,
                                                   input logic [REG_W-1:0]  src,
                                                   input logic [DATA_W-1:0] rdata);
      return (wb_we && wb_dest != '0 && wb_dest == src) ? wb_data : rdata;
   endfunction
endpackage

// File: rtl/idex_stage_if.sv
// ID-side, WB-bypass and ID/EX output bundle of the ID/EX stage.
interface idex_stage_if #(parameter int CNT_W = 16);
   import pipeline_pkg::*;

   logic               id_valid;
   logic [REG_W-1:0]   id_src1, id_src2, id_dest;
   logic               id_uses_src1, id_uses_src2, id_uses_dest;
   logic [DATA_W-1:0]  id_rdata1, id_rdata2, id_imm;
   logic               id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src;
   logic [ALUOP_W-1:0] id_alu_op;
   logic               wb_reg_write;
   logic [REG_W-1:0]   wb_dest;
   logic [DATA_W-1:0]  wb_data;
   logic               flush, ex_hold;

   logic               idex_valid, idex_reg_write, idex_mem_read, idex_mem_write;
   logic               idex_mem_to_reg, idex_alu_src;
   logic [ALUOP_W-1:0] idex_alu_op;
   logic [REG_W-1:0]   idex_src1, idex_src2, idex_dest;
   logic [DATA_W-1:0]  idex_rdata1, idex_rdata2, idex_imm;
   logic               pc_write, ifid_write;
   logic [CNT_W-1:0]   stall_count;

   modport master (
      output id_valid, id_src1, id_src2, id_dest, id_uses_src1, id_uses_src2, id_uses_dest,
             id_rdata1, id_rdata2, id_imm, id_reg_write, id_mem_read, id_mem_write,
             id_mem_to_reg, id_alu_src, id_alu_op, wb_reg_write, wb_dest, wb_data,
             flush, ex_hold,
      input  idex_valid, idex_reg_write, idex_mem_read, idex_mem_write, idex_mem_to_reg,
             idex_alu_src, idex_alu_op, idex_src1, idex_src2, idex_dest, idex_rdata1,
             idex_rdata2, idex_imm, pc_write, ifid_write, stall_count
   );

   modport slave (
      input  id_valid, id_src1, id_src2, id_dest, id_uses_src1, id_uses_src2, id_uses_dest,
             id_rdata1, id_rdata2, id_imm, id_reg_write, id_mem_read, id_mem_write,
             id_mem_to_reg, id_alu_src, id_alu_op, wb_reg_write, wb_dest, wb_data,
             flush, ex_hold,
      output idex_valid, idex_reg_write, idex_mem_read, idex_mem_write, idex_mem_to_reg,
             idex_alu_src, idex_alu_op, idex_src1, idex_src2, idex_dest, idex_rdata1,
             idex_rdata2, idex_imm, pc_write, ifid_write, stall_count
   );
endinterface

// File: rtl/idex_stage_hazard_detect.sv
// Load-use detection against the instruction in ID/EX, and the flush/hold/stall priority decode.
module hazard_detect
   import pipeline_pkg::*;
(
   input  logic             idex_valid,
   input  logic             idex_mem_read,
   input  logic [REG_W-1:0] idex_dest,
   input  logic             id_valid,
   input  logic [REG_W-1:0] id_src1,
   input  logic [REG_W-1:0] id_src2,
   input  logic [REG_W-1:0] id_dest,
   input  logic             id_uses_src1,
   input  logic             id_uses_src2,
   input  logic             id_uses_dest,
   input  logic             flush,
   input  logic             ex_hold,
   output logic             pc_write,
   output logic             ifid_write,
   output logic             insert_bubble,
   output logic             hold,
   output logic             stall_inc
);
   logic load_use;

   assign load_use = idex_valid && idex_mem_read && (idex_dest != '0) && id_valid &&
                     ((id_uses_src1 && id_src1 == idex_dest) ||
                      (id_uses_src2 && id_src2 == idex_dest) ||
                      (id_uses_dest && id_dest == idex_dest));

   // Flush beats everything: IF/ID squashes itself, so the front end keeps moving.
   always_comb begin
      pc_write      = 1'b1;
      ifid_write    = 1'b1;
      insert_bubble = 1'b0;
      hold          = 1'b0;
      stall_inc     = 1'b0;
      if (flush) begin
         insert_bubble = 1'b1;
      end else if (ex_hold) begin
         hold       = 1'b1;
         pc_write   = 1'b0;
         ifid_write = 1'b0;
      end else if (load_use) begin
         insert_bubble = 1'b1;
         pc_write      = 1'b0;
         ifid_write    = 1'b0;
         stall_inc     = 1'b1;
      end
   end
endmodule

// File: rtl/idex_stage.sv
// ID/EX pipeline register with WB-to-ID bypass, load-use bubble insertion and a saturating stall counter.
module idex_stage
   import pipeline_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic        clk,
   input  logic        reset,
   idex_stage_if.slave bus
);
   idex_t            idex_q, idex_d;
   logic [CNT_W-1:0] stall_count_q, stall_count_d;
   logic             insert_bubble, hold, stall_inc;

   hazard_detect u_hazard (
      .idex_valid    (idex_q.valid),
      .idex_mem_read (idex_q.ctrl.mem_read),
      .idex_dest     (idex_q.dest),
      .id_valid      (bus.id_valid),
      .id_src1       (bus.id_src1),
      .id_src2       (bus.id_src2),
      .id_dest       (bus.id_dest),
      .id_uses_src1  (bus.id_uses_src1),
      .id_uses_src2  (bus.id_uses_src2),
      .id_uses_dest  (bus.id_uses_dest),
      .flush         (bus.flush),
      .ex_hold       (bus.ex_hold),
      .pc_write      (bus.pc_write),
      .ifid_write    (bus.ifid_write),
      .insert_bubble (insert_bubble),
      .hold          (hold),
      .stall_inc     (stall_inc)
   );

   always_comb begin
      idex_d        = idex_q;
      stall_count_d = stall_count_q;
      if (insert_bubble) begin
         idex_d      = '0;
         idex_d.ctrl = BUBBLE_CTRL;
      end else if (!hold) begin
         // Side-effecting controls are gated so an empty ID slot cannot write anything.
         idex_d.valid           = bus.id_valid;
         idex_d.ctrl.reg_write  = bus.id_reg_write & bus.id_valid;
         idex_d.ctrl.mem_read   = bus.id_mem_read  & bus.id_valid;
         idex_d.ctrl.mem_write  = bus.id_mem_write & bus.id_valid;
         idex_d.ctrl.mem_to_reg = bus.id_mem_to_reg;
         idex_d.ctrl.alu_src    = bus.id_alu_src;
         idex_d.ctrl.alu_op     = bus.id_alu_op;
         idex_d.src1            = bus.id_src1;
         idex_d.src2            = bus.id_src2;
         idex_d.dest            = bus.id_dest;
         idex_d.rdata1 = wb_bypass(bus.wb_reg_write, bus.wb_dest, bus.wb_data, bus.id_src1, bus.id_rdata1);
         idex_d.rdata2 = wb_bypass(bus.wb_reg_write, bus.wb_dest, bus.wb_data, bus.id_src2, bus.id_rdata2);
         idex_d.imm             = bus.id_imm;
      end
      if (stall_inc && stall_count_q != '1)
         stall_count_d = stall_count_q + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         idex_q        <= '0;
         stall_count_q <= '0;
      end else begin
         idex_q        <= idex_d;
         stall_count_q <= stall_count_d;
      end
   end

   assign bus.idex_valid      = idex_q.valid;
   assign bus.idex_reg_write  = idex_q.ctrl.reg_write;
   assign bus.idex_mem_read   = idex_q.ctrl.mem_read;
   assign bus.idex_mem_write  = idex_q.ctrl.mem_write;
   assign bus.idex_mem_to_reg = idex_q.ctrl.mem_to_reg;
   assign bus.idex_alu_src    = idex_q.ctrl.alu_src;
   assign bus.idex_alu_op     = idex_q.ctrl.alu_op;
   assign bus.idex_src1       = idex_q.src1;
   assign bus.idex_src2       = idex_q.src2;
   assign bus.idex_dest       = idex_q.dest;
   assign bus.idex_rdata1     = idex_q.rdata1;
   assign bus.idex_rdata2     = idex_q.rdata2;
   assign bus.idex_imm        = idex_q.imm;
   assign bus.stall_count     = stall_count_q;
endmodule

// File: tb/tb_idex_stage.sv
// Randomized + directed bench for idex_stage; a 16-bit and a 4-bit counter instance share stimulus.
module tb_idex_stage;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   idex_stage_if #(.CNT_W(16)) if_a ();
   idex_stage_if #(.CNT_W(4))  if_b ();

   idex_stage #(.CNT_W(16)) dut_a (.clk(clk), .reset(reset), .bus(if_a.slave));
   idex_stage #(.CNT_W(4))  dut_b (.clk(clk), .reset(reset), .bus(if_b.slave));

   typedef struct {
      bit valid; bit [4:0] s1, s2, d; bit u1, u2, ud;
      bit [31:0] r1, r2, imm; bit rw, mr, mw, m2r, as; bit [3:0] op;
      bit wbw; bit [4:0] wbd; bit [31:0] wbdat; bit flush, hold;
   } stim_t;

   typedef struct {
      bit v, rw, mr, mw, m2r, as; bit [3:0] op; bit [4:0] s1, s2, d;
      bit [31:0] r1, r2, imm;
   } st_t;

   st_t         m;
   int unsigned cnt16, cnt4;
   int          n_pass = 0, n_total = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
   endtask

   task automatic apply(input stim_t s, input bit rst);
      reset = rst;
      if_a.id_valid = s.valid;  if_b.id_valid = s.valid;
      if_a.id_src1 = s.s1;      if_b.id_src1 = s.s1;
      if_a.id_src2 = s.s2;      if_b.id_src2 = s.s2;
      if_a.id_dest = s.d;       if_b.id_dest = s.d;
      if_a.id_uses_src1 = s.u1; if_b.id_uses_src1 = s.u1;
      if_a.id_uses_src2 = s.u2; if_b.id_uses_src2 = s.u2;
      if_a.id_uses_dest = s.ud; if_b.id_uses_dest = s.ud;
      if_a.id_rdata1 = s.r1;    if_b.id_rdata1 = s.r1;
      if_a.id_rdata2 = s.r2;    if_b.id_rdata2 = s.r2;
      if_a.id_imm = s.imm;      if_b.id_imm = s.imm;
      if_a.id_reg_write = s.rw; if_b.id_reg_write = s.rw;
      if_a.id_mem_read = s.mr;  if_b.id_mem_read = s.mr;
      if_a.id_mem_write = s.mw; if_b.id_mem_write = s.mw;
      if_a.id_mem_to_reg = s.m2r; if_b.id_mem_to_reg = s.m2r;
      if_a.id_alu_src = s.as;   if_b.id_alu_src = s.as;
      if_a.id_alu_op = s.op;    if_b.id_alu_op = s.op;
      if_a.wb_reg_write = s.wbw; if_b.wb_reg_write = s.wbw;
      if_a.wb_dest = s.wbd;     if_b.wb_dest = s.wbd;
      if_a.wb_data = s.wbdat;   if_b.wb_data = s.wbdat;
      if_a.flush = s.flush;     if_b.flush = s.flush;
      if_a.ex_hold = s.hold;    if_b.ex_hold = s.hold;
   endtask

   function automatic stim_t idle();
      stim_t s;
      s = '{default: 0};
      return s;
   endfunction

   function automatic stim_t rnd();
      stim_t s;
      s.valid = ($urandom_range(0, 3) != 0);
      s.s1 = 5'($urandom_range(0, 7)); s.s2 = 5'($urandom_range(0, 7)); s.d = 5'($urandom_range(0, 7));
      s.u1 = 1'($urandom); s.u2 = 1'($urandom); s.ud = 1'($urandom);
      s.r1 = $urandom; s.r2 = $urandom; s.imm = $urandom;
      s.rw = 1'($urandom); s.mr = ($urandom_range(0, 2) == 0); s.mw = 1'($urandom);
      s.m2r = 1'($urandom); s.as = 1'($urandom); s.op = 4'($urandom);
      s.wbw = 1'($urandom); s.wbd = 5'($urandom_range(0, 7)); s.wbdat = $urandom;
      s.flush = ($urandom_range(0, 9) == 0); s.hold = ($urandom_range(0, 9) == 0);
      return s;
   endfunction

   function automatic bit [31:0] byp(input stim_t s, input bit [4:0] src, input bit [31:0] rd);
      if (s.wbw && s.wbd != 0 && s.wbd == src) return s.wbdat;
      return rd;
   endfunction

   task automatic compare();
      chk("idex_valid", if_a.idex_valid, m.v);
      chk("idex_reg_write", if_a.idex_reg_write, m.rw);
      chk("idex_mem_read", if_a.idex_mem_read, m.mr);
      chk("idex_mem_write", if_a.idex_mem_write, m.mw);
      chk("idex_mem_to_reg", if_a.idex_mem_to_reg, m.m2r);
      chk("idex_alu_src", if_a.idex_alu_src, m.as);
      chk("idex_alu_op", if_a.idex_alu_op, m.op);
      chk("idex_src1", if_a.idex_src1, m.s1);
      chk("idex_src2", if_a.idex_src2, m.s2);
      chk("idex_dest", if_a.idex_dest, m.d);
      chk("idex_rdata1", if_a.idex_rdata1, m.r1);
      chk("idex_rdata2", if_a.idex_rdata2, m.r2);
      chk("idex_imm", if_a.idex_imm, m.imm);
      chk("stall_count", if_a.stall_count, cnt16);
      chk("b_idex_valid", if_b.idex_valid, m.v);
      chk("b_idex_dest", if_b.idex_dest, m.d);
      chk("b_stall_count", if_b.stall_count, cnt4);
   endtask

   // One clock: drive at negedge, check combinational outputs, advance model, check registers after the edge.
   task automatic cycle(input stim_t s, input bit rst, output bit pc_seen);
      bit lu, exp_pc;
      @(negedge clk);
      apply(s, rst);
      #1;
      lu = m.v && m.mr && (m.d != 0) && s.valid &&
           ((s.u1 && s.s1 == m.d) || (s.u2 && s.s2 == m.d) || (s.ud && s.d == m.d));
      exp_pc = s.flush ? 1'b1 : (s.hold ? 1'b0 : !lu);
      chk("pc_write", if_a.pc_write, exp_pc);
      chk("ifid_write", if_a.ifid_write, exp_pc);
      chk("b_pc_write", if_b.pc_write, exp_pc);
      pc_seen = if_a.pc_write;
      if (rst) begin
         m = '{default: 0}; cnt16 = 0; cnt4 = 0;
      end else if (s.flush) begin
         m = '{default: 0};
      end else if (s.hold) begin
         m = m;
      end else if (lu) begin
         m = '{default: 0};
         if (cnt16 < 65535) cnt16++;
         if (cnt4 < 15) cnt4++;
      end else begin
         m.v = s.valid; m.rw = s.rw & s.valid; m.mr = s.mr & s.valid; m.mw = s.mw & s.valid;
         m.m2r = s.m2r; m.as = s.as; m.op = s.op;
         m.s1 = s.s1; m.s2 = s.s2; m.d = s.d;
         m.r1 = byp(s, s.s1, s.r1); m.r2 = byp(s, s.s2, s.r2); m.imm = s.imm;
      end
      @(posedge clk);
      #1;
      compare();
   endtask

   stim_t lw, add, sw, s;
   bit    pc;

   initial begin
      m = '{default: 0}; cnt16 = 0; cnt4 = 0;
      apply(idle(), 1'b1);

      // Reset with arbitrary inputs.
      for (int i = 0; i < 2; i++) begin
         s = rnd(); s.flush = 0; s.hold = 0;
         cycle(s, 1'b1, pc);
      end
      chk("rst_idex_valid", if_a.idex_valid, 0);
      chk("rst_idex_rdata1", if_a.idex_rdata1, 0);
      chk("rst_stall_count", if_a.stall_count, 0);
      chk("rst_pc_write", if_a.pc_write, 1);
      chk("rst_ifid_write", if_a.ifid_write, 1);

      lw = idle(); lw.valid = 1; lw.mr = 1; lw.rw = 1; lw.m2r = 1; lw.as = 1;
      lw.s1 = 1; lw.u1 = 1; lw.d = 8; lw.imm = 32'h10;
      add = idle(); add.valid = 1; add.rw = 1; add.s1 = 8; add.s2 = 9; add.d = 10;
      add.u1 = 1; add.u2 = 1; add.r1 = 32'h11; add.r2 = 32'h22; add.op = 4'h2;

      // lw $8 then dependent add: exactly one bubble.
      cycle(lw, 0, pc);
      cycle(add, 0, pc);
      chk("lu_pc_write", pc, 0);
      chk("lu_bubble_valid", if_a.idex_valid, 0);
      chk("lu_bubble_src1", if_a.idex_src1, 0);
      chk("lu_stall_count", if_a.stall_count, 1);
      cycle(add, 0, pc);
      chk("lu_release_pc", pc, 1);
      chk("lu_add_src1", if_a.idex_src1, 8);
      chk("lu_add_valid", if_a.idex_valid, 1);

      // Store whose data register is the load target.
      sw = idle(); sw.valid = 1; sw.mw = 1; sw.s1 = 2; sw.u1 = 1; sw.d = 8; sw.ud = 1;
      cycle(lw, 0, pc);
      cycle(sw, 0, pc);
      chk("sw_bubble_valid", if_a.idex_valid, 0);
      chk("sw_stall_count", if_a.stall_count, 2);
      cycle(sw, 0, pc);
      chk("sw_captured", if_a.idex_mem_write, 1);

      // Load to $0 never stalls.
      s = lw; s.d = 0;
      cycle(s, 0, pc);
      s = add; s.s1 = 0;
      cycle(s, 0, pc);
      chk("r0_no_stall_pc", pc, 1);
      chk("r0_no_stall_valid", if_a.idex_valid, 1);
      chk("r0_stall_count", if_a.stall_count, 2);

      // WB bypass, and $0 never bypassed.
      s = idle(); s.valid = 1; s.s2 = 5; s.u2 = 1; s.r2 = 32'h1;
      s.wbw = 1; s.wbd = 5; s.wbdat = 32'hDEADBEEF;
      cycle(s, 0, pc);
      chk("wb_bypass", if_a.idex_rdata2, 32'hDEADBEEF);
      s.s2 = 0; s.wbd = 0;
      cycle(s, 0, pc);
      chk("wb_r0_no_bypass", if_a.idex_rdata2, 32'h1);

      // Flush beats load-use.
      cycle(lw, 0, pc);
      s = add; s.flush = 1;
      cycle(s, 0, pc);
      chk("flush_pc_write", pc, 1);
      chk("flush_bubble", if_a.idex_valid, 0);
      chk("flush_stall_count", if_a.stall_count, 2);

      // Hold for 3 cycles keeps the register contents.
      s = add; s.s1 = 3; s.imm = 32'h12345678;
      cycle(s, 0, pc);
      for (int i = 0; i < 3; i++) begin
         s = rnd(); s.flush = 0; s.hold = 1;
         cycle(s, 0, pc);
         chk("hold_pc_write", pc, 0);
         chk("hold_imm", if_a.idex_imm, 32'h12345678);
         chk("hold_src1", if_a.idex_src1, 3);
      end

      // Saturate the 4-bit counter instance.
      for (int i = 0; i < 15; i++) begin
         cycle(lw, 0, pc);
         cycle(add, 0, pc);
      end
      chk("sat_b_count", if_b.stall_count, 4'hF);
      chk("sat_a_count", if_a.stall_count, 17);

      // Randomized run against the model.
      for (int i = 0; i < 3000; i++) begin
         s = rnd();
         cycle(s, ($urandom_range(0, 99) == 0), pc);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
